// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 burst sequencer: gates an external clock divider, detects SCLK edges
// on its output and shifts DATA_W-bit words MSB first while cs_n is held low.
//
// state     | meaning
// ST_IDLE   | cs_n high, divider held in reset, waiting for start
// ST_LOAD   | cs_n low, SCLK low, waiting for the next tx word
// ST_SHIFT  | divider running, one word moving on MOSI/MISO
// ST_FINISH | cs_n kept low CS_HOLD cycles after the last falling edge
module spi_xfer_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4,
  parameter int CS_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  nbytes,
  input  logic              abort,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              div_reset,
  input  logic              div_sclk,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_cs_n,
  input  logic              spi_miso
);

  localparam int BC_W   = $clog2(DATA_W) + 1;
  localparam int HOLD_W = $clog2(CS_HOLD) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  logic [1:0]        r_state;
  logic              r_sclk_q;
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] r_rx_shift;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]  r_bytes_left;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_done;

  logic w_rise;
  logic w_fall;
  logic w_more_bits;

  assign w_rise      = div_sclk & ~r_sclk_q;
  assign w_fall      = ~div_sclk & r_sclk_q;
  assign w_more_bits = (r_bit_cnt < BC_W'(DATA_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_sclk_q     <= 1'b0;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_bit_cnt    <= '0;
      r_bytes_left <= '0;
      r_hold_cnt   <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_sclk_q   <= div_sclk;
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      // abort outranks every other event, including a word completing this cycle
      if (abort && (r_state != ST_IDLE)) begin
        r_state    <= ST_IDLE;
        r_tx_shift <= '0;
        r_rx_shift <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !abort && (nbytes != '0)) begin
              r_bytes_left <= nbytes;
              r_state      <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (tx_valid) begin
              r_tx_shift <= tx_data;
              r_bit_cnt  <= '0;
              r_state    <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (w_rise) begin
              r_rx_shift <= {r_rx_shift[DATA_W-2:0], spi_miso};
              r_bit_cnt  <= r_bit_cnt + BC_W'(1);
            end
            if (w_fall) begin
              if (w_more_bits) begin
                r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
              end else begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                if (r_bytes_left != '0) begin
                  r_bytes_left <= r_bytes_left - CNT_W'(1);
                end
                if (r_bytes_left > CNT_W'(1)) begin
                  r_state <= ST_LOAD;
                end else begin
                  r_state    <= ST_FINISH;
                  r_hold_cnt <= HOLD_W'(CS_HOLD - 1);
                end
              end
            end
          end
          ST_FINISH: begin
            if (r_hold_cnt == '0) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // MOSI is the MSB of the tx shifter, so it only moves on load or a detected fall
  assign spi_mosi  = r_tx_shift[DATA_W-1];
  assign spi_sclk  = (r_state == ST_SHIFT) & div_sclk;
  assign spi_cs_n  = (r_state == ST_IDLE);
  assign div_reset = (r_state != ST_SHIFT);
  assign tx_ready  = (r_state == ST_LOAD);
  assign busy      = (r_state != ST_IDLE);
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign done      = r_done;

endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

Transfer sequencer for the SPI master. It gates the shared clock divider through `div_reset`, detects edges on the divider's `div_sclk` output, and drives chip-select, SCLK, MOSI and MISO capture for mode 0 (CPOL=0, CPHA=0). It runs multi-byte bursts of 1..2^CNT_W-1 bytes, MSB first. Data moves through a per-byte tx handshake and an rx strobe, and an abort input is provided.

## Interface
- DATA_W, 8, bits per SPI word
- CNT_W, 4, width of burst byte count
- CS_HOLD, 4, clk cycles cs_n stays low after last falling SCLK edge (≥1)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  begin burst; sampled only in IDLE
- nbytes  in  CNT_W  burst length, latched with start; 0 = start ignored
- abort  in  1  terminate burst immediately
- tx_data  in  DATA_W  next word to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  controller accepts tx_data this cycle
- rx_data  out  DATA_W  last received word
- rx_valid  out  1  one-cycle strobe, rx_data updated
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle strobe at normal burst completion
- div_reset  out  1  to clock divider reset input; holds divider counter at 0
- div_sclk  in  1  divider output (counter MSB: 16 clk low, 16 clk high after release)
- spi_sclk, spi_mosi, spi_cs_n  out  1  SPI pins
- spi_miso  in  1  SPI pin

## Operation
- Reset values: state IDLE, tx_ready 0, rx_data 0, rx_valid 0, busy 0, done 0, div_reset 1, spi_sclk 0, spi_mosi 0, spi_cs_n 1, internal sclk_q 0.
- Edge detect: sclk_q <= div_sclk every cycle. rise = div_sclk & ~sclk_q; fall = ~div_sclk & sclk_q. Both are combinational in the same cycle as the div_sclk change.
- spi_sclk = div_sclk when state is SHIFT, else 0.
- IDLE: cs_n 1, div_reset 1. start with nbytes≠0 latches bytes_left = nbytes and goes to LOAD.
- LOAD: cs_n 0, div_reset 1, tx_ready 1. On tx_valid: shift register ← tx_data, mosi ← tx_data[DATA_W-1], bit_cnt ← 0, go to SHIFT. Without tx_valid the state stalls indefinitely with SCLK low and CS asserted.
- SHIFT: div_reset 0.
  - On rise: rx shift ← {rx_shift[DATA_W-2:0], spi_miso}; bit_cnt++.
  - On fall with bit_cnt < DATA_W: shift tx left; mosi ← next bit.
  - On fall with bit_cnt == DATA_W: next cycle rx_data ← rx shift and rx_valid = 1; bytes_left--. Go to LOAD if bytes_left was >1, else FINISH.
- FINISH: cs_n 0, div_reset 1, count CS_HOLD cycles. Then go to IDLE; done = 1 in that IDLE entry cycle, with cs_n already 1.
- abort in any non-IDLE state: next cycle is IDLE with cs_n 1, div_reset 1, sclk 0, mosi 0. The partial rx word is discarded, and no rx_valid or done is issued.
- abort and start together in IDLE: start ignored.
- start while busy: ignored.
- Reset mid-burst: all outputs return to reset values on the next edge; no done.
- bit_cnt is CLOG2(DATA_W)+1 wide; bytes_left is CNT_W wide and never wraps, since it is decremented only when ≥1.

## Timing
- A word takes 257 SHIFT cycles: counter index k = 0..256; rises at k = 16+32i; falls at k = 32+32i; final fall at k = 256.
- Latency with tx_valid held high: start at cycle 0, LOAD at cycle 1, SHIFT cycles 2..258, first rise at cycle 18, final fall at cycle 258, rx_valid at cycle 259.
- Gap between words: the LOAD cycle(s) plus the divider restart, i.e. ≥1 cycle with SCLK low.
- FINISH occupies cycles 259..258+CS_HOLD. done and cs_n=1 at cycle 259+CS_HOLD.
- MOSI changes only at cycles of a detected fall or at LOAD acceptance. MISO is sampled only at rise cycles.

## Test plan
- Single byte, tx 0xA5, MISO looped to MOSI, CS_HOLD=4 → 8 SCLK pulses; rx_data 0xA5 with rx_valid at cycle 259; done and cs_n high at cycle 263.
- Three-byte burst 0x01, 0x80, 0xFF, MISO tied 1 → three rx_valid strobes, each rx_data 0xFF. cs_n stays low throughout, with one done only after the third byte.
- tx_valid withheld 50 cycles in LOAD of byte 2 → SCLK low and cs_n low during the stall; transfer resumes correctly.
- abort at SHIFT cycle 100 → next cycle cs_n 1 and sclk 0; no rx_valid or done; a new start succeeds afterwards.
- start with nbytes=0, and start while busy → no state change, busy unaffected, no done.
- reset asserted mid-word → all outputs at reset values the following cycle.
